sldu_p2_pass_seq: RTL and testbench
===================================

Name: sldu_p2_pass_seq

Overview:
- Sequencer that sits directly downstream of the slide-unit power-of-two stride generator.
- Accepts one slide request (total stride, beats per pass, direction) and loads the stride into the generator.
- Emits one pass of N beats for each power-of-two component, then pulses the generator's update so the next component appears.
- Its output beat stream drives the per-pass shift network of the SLDU.

Parameters:
- NrLanes, 4, number of lanes; StrideW = idx_width(8*NrLanes), PopcW = idx_width(StrideW)+1.
- BeatW, 16, width of the beats-per-pass count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready (IDLE only)
- req_stride_i  in  StrideW  total slide stride in bytes
- req_nbeats_i  in  BeatW  beats per pass
- req_dir_i  in  1  0 = slide up, 1 = slide down
- gen_stride_o  out  StrideW  stride to generator (= req_stride_i)
- gen_valid_o  out  1  generator load strobe
- gen_update_o  out  1  generator advance strobe
- gen_popc_i  in  PopcW  generator popcount (number of passes)
- gen_stride_p2_i  in  StrideW  current power-of-two component
- gen_valid_i  in  1  component non-zero
- pass_valid_o  out  1  beat valid
- pass_ready_i  in  1  beat ready
- pass_stride_o  out  StrideW  power-of-two stride of this beat (= gen_stride_p2_i)
- pass_dir_o  out  1  latched direction
- pass_beat_o  out  BeatW  beat index within pass
- pass_idx_o  out  PopcW  pass index, from 0
- pass_last_o  out  1  last beat of last pass
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Reset: state IDLE; all counters and latched fields 0; all outputs 0 except req_ready_o=1. Reset mid-operation aborts at once; no done_o is emitted. The generator is reset by the same rst_i.
- IDLE:
  - req_ready_o=1. Accept on req_valid_i in cycle t; latch nbeats and dir.
  - If nbeats!=0: gen_valid_o=1 combinationally in cycle t, then go to LOAD.
  - If nbeats==0: gen_valid_o stays 0; go to DONE.
- LOAD (t+1):
  - Generator outputs are valid for the new stride. Capture pass_left=gen_popc_i; clear beat and pass counters.
  - If gen_valid_i=1, go to RUN; else (stride 0) go to DONE.
- RUN:
  - pass_valid_o=1. A handshake is pass_valid_o & pass_ready_i.
  - Each handshake increments pass_beat_o.
  - On the handshake at beat nbeats-1:
    - assert gen_update_o in the same cycle, combinationally;
    - wrap pass_beat_o to 0, increment pass_idx_o, decrement pass_left;
    - if pass_left==1, go to DONE.
  - The generator presents the next component on the following cycle. No bubble between passes.
- pass_last_o = RUN & pass_left==1 & pass_beat_o==nbeats-1.
- Backpressure: while pass_ready_i=0, every pass_* output holds stable and gen_update_o=0.
- DONE: done_o=1 for one cycle, then IDLE. req_ready_o returns 1 the cycle after done_o.
- Components arrive lowest set bit first. pass_stride_o is passed through unregistered.
- Protocol check (assertion, not logic): gen_valid_i must be 1 throughout RUN.
- Widths: counters wrap-free by construction (pass_left ≤ StrideW).

Decomposition:
- Shared package (ara_pkg): sldu_pass_state_e enum; a StrideW/PopcW helper function of NrLanes.
- No sub-module. The stride generator is instantiated beside this block by the SLDU top, not inside it.

Test Plan:
- NrLanes=4, stride 13, nbeats 3, ready=1: accept t, first beat t+2.
  - pass_stride 1,1,1,4,4,4,8,8,8; pass_idx 0,0,0,1,1,1,2,2,2.
  - gen_update_o at beats 3, 6, 9; pass_last_o on beat 9 only; done_o at t+11.
- Stride 16, nbeats 1: a single beat with stride 16 and pass_last_o=1; done_o the cycle after.
- Stride 0, nbeats 4: gen_valid_o at t, no pass_valid_o, done_o at t+2, req_ready_o at t+3.
- Nbeats 0, stride 7: gen_valid_o never asserted, no beats, done_o at t+1.
- Stride 5, nbeats 2, pass_ready_i alternating 0/1 starting at 0: pass outputs stable while stalled; 4 beats total; update only on handshakes 2 and 4.
- Stride 31, nbeats 2, rst_i asserted during the third beat: next cycle IDLE, req_ready_o=1, no done_o, outputs 0; a new request then runs cleanly.

Source files
------------

// File: rtl/sldu_p2_pass_seq_pkg.sv
// Shared types and width helpers for the SLDU power-of-two pass sequencer.
// Provides the sequencer state enum and StrideW/PopcW derivations from NrLanes.
package sldu_p2_pass_seq_pkg;

  localparam int unsigned NrLanesDef = 4;
  localparam int unsigned BeatWDef   = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned stride_w(input int unsigned lanes);
    return idx_width(8 * lanes);
  endfunction

  function automatic int unsigned popc_w(input int unsigned lanes);
    return idx_width(stride_w(lanes)) + 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } sldu_pass_state_e;

endpackage

// File: rtl/sldu_p2_pass_seq.sv
// Sequencer downstream of the SLDU power-of-two stride generator: one pass
// of nbeats beats per set stride bit, lowest bit first.
// Ports: clk_i/rst_i (sync, active high); req_* slide request (ready in IDLE);
// gen_* load/advance strobes to and component/popcount from the generator;
// pass_* beat stream with valid/ready; busy_o; done_o completion pulse.
module sldu_p2_pass_seq
  import sldu_p2_pass_seq_pkg::*;
#(
  parameter int unsigned NrLanes = NrLanesDef,
  parameter int unsigned BeatW   = BeatWDef,
  parameter int unsigned StrideW = stride_w(NrLanes),
  parameter int unsigned PopcW   = popc_w(NrLanes)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [StrideW-1:0] req_stride_i,
  input  logic [BeatW-1:0]   req_nbeats_i,
  input  logic               req_dir_i,
  output logic [StrideW-1:0] gen_stride_o,
  output logic               gen_valid_o,
  output logic               gen_update_o,
  input  logic [PopcW-1:0]   gen_popc_i,
  input  logic [StrideW-1:0] gen_stride_p2_i,
  input  logic               gen_valid_i,
  output logic               pass_valid_o,
  input  logic               pass_ready_i,
  output logic [StrideW-1:0] pass_stride_o,
  output logic               pass_dir_o,
  output logic [BeatW-1:0]   pass_beat_o,
  output logic [PopcW-1:0]   pass_idx_o,
  output logic               pass_last_o,
  output logic               busy_o,
  output logic               done_o
);

  sldu_pass_state_e state_q, state_d;
  logic [BeatW-1:0] nbeats_q, nbeats_d;
  logic             dir_q, dir_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [PopcW-1:0] idx_q, idx_d;
  logic [PopcW-1:0] left_q, left_d;

  logic run;
  logic last_beat;

  assign run       = (state_q == S_RUN);
  assign last_beat = (beat_q == nbeats_q - BeatW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      nbeats_q <= '0;
      dir_q    <= 1'b0;
      beat_q   <= '0;
      idx_q    <= '0;
      left_q   <= '0;
    end else begin
      state_q  <= state_d;
      nbeats_q <= nbeats_d;
      dir_q    <= dir_d;
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      left_q   <= left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nbeats_d     = nbeats_q;
    dir_d        = dir_q;
    beat_d       = beat_q;
    idx_d        = idx_q;
    left_d       = left_q;
    req_ready_o  = 1'b0;
    gen_valid_o  = 1'b0;
    gen_update_o = 1'b0;
    pass_valid_o = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          nbeats_d = req_nbeats_i;
          dir_d    = req_dir_i;
          // Zero-beat requests never touch the generator.
          if (req_nbeats_i != '0) begin
            gen_valid_o = 1'b1;
            state_d     = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        left_d  = gen_popc_i;
        beat_d  = '0;
        idx_d   = '0;
        state_d = gen_valid_i ? S_RUN : S_DONE;
      end
      S_RUN: begin
        pass_valid_o = 1'b1;
        if (pass_ready_i) begin
          if (last_beat) begin
            // Advance now so the next component is ready next cycle.
            gen_update_o = 1'b1;
            beat_d       = '0;
            idx_d        = idx_q + PopcW'(1);
            left_d       = left_q - PopcW'(1);
            if (left_q == PopcW'(1)) begin
              state_d = S_DONE;
            end
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gen_stride_o  = req_stride_i;
  assign pass_stride_o = run ? gen_stride_p2_i : '0;
  assign pass_dir_o    = run & dir_q;
  assign pass_beat_o   = run ? beat_q : '0;
  assign pass_idx_o    = run ? idx_q : '0;
  assign pass_last_o   = run & (left_q == PopcW'(1)) & last_beat;
  assign busy_o        = (state_q != S_IDLE);

  a_gen_valid_run: assert property (
    @(posedge clk_i) disable iff (rst_i) (state_q == S_RUN) |-> gen_valid_i
  );

endmodule

// File: tb/tb_sldu_p2_pass_seq.sv
// Bench for sldu_p2_pass_seq with a behavioural stride generator and an
// expected-beat queue built from the request's set bits.
module tb_sldu_p2_pass_seq;
  import sldu_p2_pass_seq_pkg::*;

  localparam int SW = stride_w(NrLanesDef);
  localparam int PW = popc_w(NrLanesDef);
  localparam int BW = BeatWDef;

  typedef struct {
    logic [SW-1:0] st;
    logic [BW-1:0] beat;
    logic [PW-1:0] idx;
    logic          last;
    logic          upd;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready_o;
  logic [SW-1:0] req_stride;
  logic [BW-1:0] req_nbeats;
  logic          req_dir;
  logic [SW-1:0] gen_stride_o;
  logic          gen_valid_o;
  logic          gen_update_o;
  logic [PW-1:0] gen_popc_i;
  logic [SW-1:0] gen_stride_p2_i;
  logic          gen_valid_i;
  logic          pass_valid_o;
  logic          pass_ready;
  logic [SW-1:0] pass_stride_o;
  logic          pass_dir_o;
  logic [BW-1:0] pass_beat_o;
  logic [PW-1:0] pass_idx_o;
  logic          pass_last_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sldu_p2_pass_seq dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .req_stride_i    (req_stride),
    .req_nbeats_i    (req_nbeats),
    .req_dir_i       (req_dir),
    .gen_stride_o    (gen_stride_o),
    .gen_valid_o     (gen_valid_o),
    .gen_update_o    (gen_update_o),
    .gen_popc_i      (gen_popc_i),
    .gen_stride_p2_i (gen_stride_p2_i),
    .gen_valid_i     (gen_valid_i),
    .pass_valid_o    (pass_valid_o),
    .pass_ready_i    (pass_ready),
    .pass_stride_o   (pass_stride_o),
    .pass_dir_o      (pass_dir_o),
    .pass_beat_o     (pass_beat_o),
    .pass_idx_o      (pass_idx_o),
    .pass_last_o     (pass_last_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  // Generator: remaining stride bits; update clears the lowest one.
  logic [SW-1:0] g_rem;
  always_ff @(posedge clk) begin
    if (rst) g_rem <= '0;
    else if (gen_valid_o) g_rem <= gen_stride_o;
    else if (gen_update_o) g_rem <= g_rem & (g_rem - SW'(1));
  end
  assign gen_popc_i      = PW'($countones(g_rem));
  assign gen_stride_p2_i = g_rem & (~g_rem + SW'(1));
  assign gen_valid_i     = |g_rem;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pvalid"}, pass_valid_o, 0);
    chk({tag, "_update"}, gen_update_o, 0);
    chk({tag, "_beat"}, pass_beat_o, 0);
    chk({tag, "_idx"}, pass_idx_o, 0);
    chk({tag, "_last"}, pass_last_o, 0);
  endtask

  // mode 0: ready=1, 1: alternate starting 0, 2: random.
  // abort_hs>0: assert reset while beat number abort_hs+1 is shown.
  task automatic run_req(input logic [SW-1:0] s, input logic [BW-1:0] nb,
                         input logic d, input int mode, input int abort_hs);
    beat_t q[$];
    beat_t e;
    int n, p, hs, last_hs, exp_done;
    bit fin;
    n = $countones(s);
    p = 0;
    if (nb != 0) begin
      for (int k = 0; k < SW; k++) begin
        if (s[k]) begin
          for (int b = 0; b < int'(nb); b++) begin
            e.st   = SW'(1) << k;
            e.beat = BW'(b);
            e.idx  = PW'(p);
            e.upd  = (b == int'(nb) - 1);
            e.last = e.upd && (p == n - 1);
            q.push_back(e);
          end
          p++;
        end
      end
    end
    @(negedge clk);
    chk("req_ready_idle", req_ready_o, 1);
    req_valid  = 1'b1;
    req_stride = s;
    req_nbeats = nb;
    req_dir    = d;
    #1;
    chk("gen_valid_accept", gen_valid_o, nb != 0);
    chk("gen_stride", gen_stride_o, s);
    hs = 0;
    last_hs = 0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      req_stride = SW'($urandom);
      pass_ready = (mode == 0) ? 1'b1 :
                   (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      #1;
      if (abort_hs != 0 && hs == abort_hs) begin
        chk("abort_beat_shown", pass_valid_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge clk);
        #1;
        chk("abort_no_done", done_o, 0);
        return;
      end
      chk("busy", busy_o, 1);
      chk("req_ready_busy", req_ready_o, 0);
      chk("pass_valid", pass_valid_o, cyc >= 2 && q.size() != 0);
      if (pass_valid_o && q.size() != 0) begin
        chk("pass_stride", pass_stride_o, q[0].st);
        chk("pass_beat", pass_beat_o, q[0].beat);
        chk("pass_idx", pass_idx_o, q[0].idx);
        chk("pass_last", pass_last_o, q[0].last);
        chk("pass_dir", pass_dir_o, d);
        chk("gen_update", gen_update_o, pass_ready && q[0].upd);
        if (pass_ready) begin
          void'(q.pop_front());
          hs++;
          last_hs = cyc;
        end
      end else begin
        chk("gen_update_idle", gen_update_o, 0);
      end
      exp_done = (nb == 0) ? 1 : (n == 0) ? 2 :
                 (q.size() == 0) ? last_hs + 1 : -1;
      chk("done", done_o, cyc == exp_done);
      if (done_o) fin = 1'b1;
    end
    chk("finished", fin, 1);
    chk("beats_left", q.size(), 0);
    @(negedge clk);
    #1;
    chk_idle("post_done");
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_stride = '0;
    req_nbeats = '0;
    req_dir    = 1'b0;
    pass_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_gen_valid", gen_valid_o, 0);
    rst = 1'b0;

    run_req(SW'(13), BW'(3), 1'b0, 0, 0);
    run_req(SW'(16), BW'(1), 1'b1, 0, 0);
    run_req(SW'(0),  BW'(4), 1'b0, 0, 0);
    run_req(SW'(7),  BW'(0), 1'b1, 0, 0);
    run_req(SW'(5),  BW'(2), 1'b0, 1, 0);
    run_req(SW'(31), BW'(2), 1'b1, 0, 2);
    run_req(SW'(31), BW'(2), 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      run_req(SW'($urandom), BW'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
